// File: rtl/mdu.sv
// -----------------------------------------------------------------------------
// mdu - multiply/divide unit for the E stage of the pipelined MIPS core.
//
// Owns the architectural HI/LO registers. A MULT/MULTU/DIV/DIVU command is
// accepted only while idle. The result is computed from the operands at the
// accept edge and parked in a shadow register. It is committed to HI/LO on the
// edge where the cycle counter expires, which is also the edge where busy falls.
// MTHI/MTLO write HI/LO in a single edge and never raise busy.
//
// Parameters:
//   MULT_CYCLES  busy cycles for MULT/MULTU (and MADD), legal 1..15
//   DIV_CYCLES   busy cycles for DIV/DIVU, legal 1..15
//
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-high reset, clears all state
//   start  command valid this cycle
//   op     0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 MADD
//   A, B   rs / rt operands
//   busy   registered, high while an operation is in flight
//   HI, LO architectural HI/LO registers
//
// Build option:
//   MDU_MADD_EN  when defined, op 7 is a signed multiply-accumulate into
//                {HI,LO}. When undefined, op 7 behaves as NONE.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  typedef enum logic [2:0] {
    OP_NONE  = 3'd0,
    OP_MULT  = 3'd1,
    OP_MULTU = 3'd2,
    OP_DIV   = 3'd3,
    OP_DIVU  = 3'd4,
    OP_MTHI  = 3'd5,
    OP_MTLO  = 3'd6,
    OP_MADD  = 3'd7
  } op_e;

  typedef enum logic {IDLE, RUN} state_e;

  state_e      state, state_next;
  op_e         cmd;
  logic        launch;
  logic        is_div;
  logic [3:0]  load_count;
  logic [63:0] launch_result;

  logic [3:0]  count;
  logic [63:0] result;     // shadow result awaiting commit
  logic        result_wr;  // cleared for divide-by-zero so HI/LO stay put
`ifdef MDU_MADD_EN
  logic        accumulate;
`endif

  // Datapath operands for the shared divider.
  logic        a_neg, b_neg;
  logic [31:0] dvd, dvs, quo, rem;

  assign cmd    = op_e'(op);
  assign busy   = (state == RUN);
  assign is_div = (cmd == OP_DIV) || (cmd == OP_DIVU);

  // NOTE: every signal driven from always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    launch = 1'b0;
    if (start && state == IDLE) begin
      case (cmd)
        OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: launch = 1'b1;
`ifdef MDU_MADD_EN
        OP_MADD:                            launch = 1'b1;
`endif
        default:                            launch = 1'b0;
      endcase
    end
  end

  assign load_count = is_div ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);

  // Signed division runs on magnitudes and the signs are fixed up afterwards.
  // The quotient truncates toward zero, and the remainder takes the sign of the
  // dividend. The 0x80000000 / -1 case falls out naturally: the magnitude
  // quotient 0x80000000 negates to itself, and the remainder is 0.
  always_comb begin
    a_neg = (cmd == OP_DIV) && A[31];
    b_neg = (cmd == OP_DIV) && B[31];
    dvd   = a_neg ? -A : A;
    dvs   = b_neg ? -B : B;
    if (dvs == '0) dvs = 32'd1;   // keeps the divider defined; result discarded
    quo   = dvd / dvs;
    rem   = dvd % dvs;
    if (a_neg ^ b_neg) quo = -quo;
    if (a_neg)         rem = -rem;
  end

  always_comb begin
    launch_result = '0;
    case (cmd)
      OP_MULT, OP_MADD: launch_result = {{32{A[31]}}, A} * {{32{B[31]}}, B};
      OP_MULTU:         launch_result = {32'd0, A} * {32'd0, B};
      OP_DIV, OP_DIVU:  launch_result = {rem, quo};
      default:          launch_result = '0;
    endcase
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (launch) state_next = RUN;
      RUN:     if (count == 4'd1) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments, so every register
  // samples pre-edge values and the update order within the block is irrelevant.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count      <= '0;
      result     <= '0;
      result_wr  <= 1'b0;
      HI         <= '0;
      LO         <= '0;
`ifdef MDU_MADD_EN
      accumulate <= 1'b0;
`endif
    end else if (state == IDLE) begin
      if (launch) begin
        count      <= load_count;
        result     <= launch_result;
        result_wr  <= !(is_div && B == '0);
`ifdef MDU_MADD_EN
        accumulate <= (cmd == OP_MADD);
`endif
      end else if (start && cmd == OP_MTHI) begin
        HI <= A;
      end else if (start && cmd == OP_MTLO) begin
        LO <= A;
      end
    end else begin
      count <= count - 4'd1;
      if (count == 4'd1 && result_wr) begin
`ifdef MDU_MADD_EN
        // HI/LO are frozen during RUN, so this base equals the value at start.
        {HI, LO} <= accumulate ? ({HI, LO} + result) : result;
`else
        {HI, LO} <= result;
`endif
      end
    end
  end

endmodule

// File: tb/tb_mdu.sv
// -----------------------------------------------------------------------------
// tb_mdu - directed self-checking bench for mdu with hand-computed expectations.
// Inputs change on the falling edge. Outputs are sampled 1 ns after the rising
// edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_mdu;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] A, B;
  logic        busy;
  logic [31:0] HI, LO;

  int n_compared   = 0;
  int n_mismatched = 0;

  mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .A     (A),
    .B     (B),
    .busy  (busy),
    .HI    (HI),
    .LO    (LO)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // Present one command for a single edge, then scramble the operands to show
  // that the unit latched them.
  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = 1'b1; op = o; A = a; B = b;
    @(posedge clk); #1;
    start = 1'b0; op = 3'd0; A = 32'hDEAD_BEEF; B = 32'h0000_1234;
  endtask

  // Issue, measure how many sampled cycles busy stays high, then check HI/LO.
  task automatic run_op(input string tag, input logic [2:0] o,
                        input logic [31:0] a, input logic [31:0] b,
                        input int exp_cycles,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int n;
    issue(o, a, b);
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      n++;
      @(posedge clk); #1;
    end
    check({tag, " busy_cycles"}, n, exp_cycles);
    check({tag, " HI"}, HI, exp_hi);
    check({tag, " LO"}, LO, exp_lo);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; op = 3'd0; A = '0; B = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset HI", HI, 32'd0);
    check("reset LO", LO, 32'd0);
    @(negedge clk) reset = 1'b0;

    // Basic arithmetic.
    run_op("mult -2*3",     3'd1, 32'hFFFF_FFFE, 32'd3,         5, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    run_op("multu max*max", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5, 32'hFFFF_FFFE, 32'h0000_0001);
    run_op("div -7/2",      3'd3, 32'hFFFF_FFF9, 32'd2,        10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("div ovf",       3'd3, 32'h8000_0000, 32'hFFFF_FFFF,10, 32'h0000_0000, 32'h8000_0000);
    run_op("divu 100/7",    3'd4, 32'd100,       32'd7,        10, 32'd2,         32'd14);
    run_op("div 7/-2",      3'd3, 32'd7,         32'hFFFF_FFFE,10, 32'd1,         32'hFFFF_FFFD);

    // A command on the edge where busy falls is ignored; the next edge is accepted.
    begin
      issue(3'd1, 32'd2, 32'd3);
      repeat (4) begin @(posedge clk); #1; end
      check("b2b busy before fall", {31'd0, busy}, 32'd1);
      @(negedge clk);
      start = 1'b1; op = 3'd5; A = 32'h99;
      @(posedge clk); #1;
      check("b2b busy fell", {31'd0, busy}, 32'd0);
      check("b2b mthi ignored HI", HI, 32'd0);
      check("b2b result LO", LO, 32'd6);
      @(posedge clk); #1;
      start = 1'b0; op = 3'd0;
      check("b2b restart HI", HI, 32'h99);
    end

    // MTHI/MTLO are single-edge writes, and divide by zero leaves HI/LO alone.
    run_op("mthi", 3'd5, 32'h11, 32'd0, 0, 32'h11, 32'd6);
    run_op("mtlo", 3'd6, 32'h22, 32'd0, 0, 32'h11, 32'h22);
    run_op("divu by0", 3'd4, 32'd100, 32'd0, 10, 32'h11, 32'h22);

    // MTLO during RUN is ignored; reset mid-RUN clears state immediately.
    begin
      issue(3'd1, 32'd5, 32'd5);
      check("abort busy", {31'd0, busy}, 32'd1);
      @(negedge clk);
      start = 1'b1; op = 3'd6; A = 32'h55;
      @(posedge clk); #1;
      start = 1'b0; op = 3'd0;
      check("abort mtlo ignored", LO, 32'h22);
      @(negedge clk);
      reset = 1'b1;
      #1;
      check("async reset busy", {31'd0, busy}, 32'd0);
      check("async reset HI", HI, 32'd0);
      check("async reset LO", LO, 32'd0);
      @(negedge clk) reset = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      check("post-reset busy", {31'd0, busy}, 32'd0);
      check("post-reset HI", HI, 32'd0);
      check("post-reset LO", LO, 32'd0);
    end

    // MADD, or NONE when the feature is compiled out.
    run_op("madd mthi", 3'd5, 32'd0,         32'd0, 0, 32'd0, 32'd0);
    run_op("madd mtlo", 3'd6, 32'hFFFF_FFFF, 32'd0, 0, 32'd0, 32'hFFFF_FFFF);
`ifdef MDU_MADD_EN
    run_op("madd 1*1",  3'd7, 32'd1, 32'd1, 5, 32'd1, 32'd0);
`else
    run_op("op7 none",  3'd7, 32'd1, 32'd1, 0, 32'd0, 32'hFFFF_FFFF);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
